// File: rtl/blinker_pkg.sv
// Shared board-level definitions: debounce FSM state encoding and timing constants.
package blinker_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } debounce_state_t;

   localparam int CLK_HZ      = 100_000_000;
   localparam int DEBOUNCE_MS = 10;
   localparam int HOLD_MS     = 1000;

   // Milliseconds to clock cycles at CLK_HZ.
   function automatic int ms_to_cycles(input int ms);
      return (CLK_HZ / 1000) * ms;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-FF synchronizer, debounce FSM with stability counter,
// and a long-hold detector that fires once per press.
module debounce_channel
   import blinker_pkg::*;
#(
   parameter int COUNT_WIDTH  = 32,
   parameter int STABLE_COUNT = 1_000_000,
   parameter int HOLD_COUNT   = 100_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall,
   output logic o_held
);

   localparam logic [COUNT_WIDTH-1:0] C_STABLE_LAST = COUNT_WIDTH'(STABLE_COUNT - 1);
   localparam logic [COUNT_WIDTH-1:0] C_HOLD        = COUNT_WIDTH'(HOLD_COUNT);
   localparam logic [COUNT_WIDTH-1:0] C_HOLD_LAST   = COUNT_WIDTH'(HOLD_COUNT - 1);
   localparam logic [COUNT_WIDTH-1:0] C_ONE         = COUNT_WIDTH'(1);

   logic                   r_s1, r_s2;
   debounce_state_t        r_state;
   logic [COUNT_WIDTH-1:0] r_cnt;
   logic                   r_level, r_rise, r_fall;
   logic [COUNT_WIDTH-1:0] r_hcnt;
   logic                   r_hold_done, r_held;

   // Bring the asynchronous pin into the clock domain; only r_s2 is used below.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
      end
   end

   // Accept a new level only after STABLE_COUNT identical samples; any bounce restarts.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE_LOW;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            IDLE_LOW: begin
               if (r_s2) begin
                  r_state <= WAIT_HIGH;
                  r_cnt   <= C_ONE;
               end
            end
            WAIT_HIGH: begin
               if (!r_s2) begin
                  r_state <= IDLE_LOW;
                  r_cnt   <= '0;
               end else if (r_cnt == C_STABLE_LAST) begin
                  r_state <= IDLE_HIGH;
                  r_level <= 1'b1;
                  r_rise  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            IDLE_HIGH: begin
               if (!r_s2) begin
                  r_state <= WAIT_LOW;
                  r_cnt   <= C_ONE;
               end
            end
            WAIT_LOW: begin
               if (r_s2) begin
                  r_state <= IDLE_HIGH;
                  r_cnt   <= '0;
               end else if (r_cnt == C_STABLE_LAST) begin
                  r_state <= IDLE_LOW;
                  r_level <= 1'b0;
                  r_fall  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            default: begin
               r_state <= IDLE_LOW;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Count cycles of accepted-high level (including the release window); pulse once, saturate.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hcnt      <= '0;
         r_hold_done <= 1'b0;
         r_held      <= 1'b0;
      end else if (!r_level) begin
         r_hcnt      <= '0;
         r_hold_done <= 1'b0;
         r_held      <= 1'b0;
      end else begin
         r_held <= 1'b0;
         if (r_hcnt != C_HOLD) r_hcnt <= r_hcnt + C_ONE;
         if (!r_hold_done && (r_hcnt == C_HOLD_LAST)) begin
            r_held      <= 1'b1;
            r_hold_done <= 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
   assign o_held  = r_held;

endmodule

// File: rtl/button_debouncer.sv
// Board input conditioner: INPUT_WIDTH independent debounce channels.
module button_debouncer
   import blinker_pkg::*;
#(
   parameter int COUNT_WIDTH  = 32,
   parameter int STABLE_COUNT = ms_to_cycles(DEBOUNCE_MS),
   parameter int HOLD_COUNT   = ms_to_cycles(HOLD_MS),
   parameter int INPUT_WIDTH  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [INPUT_WIDTH-1:0] i_raw_in,
   output logic [INPUT_WIDTH-1:0] o_level,
   output logic [INPUT_WIDTH-1:0] o_rise,
   output logic [INPUT_WIDTH-1:0] o_fall,
   output logic [INPUT_WIDTH-1:0] o_held
);

   for (genvar g = 0; g < INPUT_WIDTH; g++) begin : g_ch
      debounce_channel #(
         .COUNT_WIDTH  (COUNT_WIDTH),
         .STABLE_COUNT (STABLE_COUNT),
         .HOLD_COUNT   (HOLD_COUNT)
      ) u_ch (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_raw   (i_raw_in[g]),
         .o_level (o_level[g]),
         .o_rise  (o_rise[g]),
         .o_fall  (o_fall[g]),
         .o_held  (o_held[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with short debounce/hold windows.
module tb_button_debouncer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] raw = '0;
   logic [W-1:0] level, rise, fall, held;

   int n_err = 0;
   int n_chk = 0;

   button_debouncer #(
      .COUNT_WIDTH  (32),
      .STABLE_COUNT (4),
      .HOLD_COUNT   (8),
      .INPUT_WIDTH  (W)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_raw_in (raw),
      .o_level  (level),
      .o_rise   (rise),
      .o_fall   (fall),
      .o_held   (held)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges; returns at the following falling edge.
   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // rise and fall must never coincide on any bit.
   always @(negedge clk) if (!rst) chk("excl", 32'(rise & fall), 32'd0);

   initial begin
      // Reset state
      ticks(2);
      chk("rst_outs", {level, rise, fall, held}, 16'h0000);

      // Release reset with all buttons pressed
      rst = 1'b0;
      raw = 4'b1111;
      ticks(6);
      chk("all_lvl", 32'(level), 32'hf);
      chk("all_rise", 32'(rise), 32'hf);
      ticks(3);

      // Asynchronous reset mid-hold clears everything without a clock edge
      #2 rst = 1'b1;
      #1 chk("async_rst", {level, rise, fall, held}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      ticks(5);
      chk("rst_lvl_early", 32'(level), 32'h0);
      ticks(1);
      chk("rst_lvl", 32'(level), 32'hf);
      chk("rst_rise", 32'(rise), 32'hf);
      ticks(1);
      chk("rst_rise_clr", 32'(rise), 32'h0);
      // Hold counter restarted from zero after reset
      ticks(6);
      chk("rst_held_early", 32'(held), 32'h0);
      ticks(1);
      chk("rst_held", 32'(held), 32'hf);
      for (int i = 0; i < 6; i++) begin
         ticks(1);
         chk("rst_held_once", 32'(held), 32'h0);
      end
      raw = 4'b0000;
      ticks(5);
      chk("all_fall_early", 32'(fall), 32'h0);
      ticks(1);
      chk("all_fall", 32'(fall), 32'hf);
      chk("all_lvl_low", 32'(level), 32'h0);
      ticks(2);

      // Clean press on bit 0
      raw = 4'b0001;
      ticks(5);
      chk("press_early", {level, rise}, 8'h00);
      ticks(1);
      chk("press_lvl", 32'(level), 32'h1);
      chk("press_rise", 32'(rise), 32'h1);
      ticks(1);
      chk("press_rise_clr", 32'(rise), 32'h0);
      raw = 4'b0000;
      ticks(8);
      chk("press_release", 32'(level), 32'h0);

      // Bounce on bit 1: never more than two matching samples
      for (int i = 0; i < 4; i++) begin
         raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         for (int j = 0; j < 2; j++) begin
            ticks(1);
            chk("bounce", 32'({level[1], rise[1], fall[1]}), 32'h0);
         end
      end
      for (int j = 0; j < 8; j++) begin
         ticks(1);
         chk("bounce_tail", 32'({level[1], rise[1], fall[1]}), 32'h0);
      end

      // Near-miss on bit 2: three samples are not enough
      raw = 4'b0100;
      ticks(3);
      raw = 4'b0000;
      for (int j = 0; j < 8; j++) begin
         ticks(1);
         chk("near_miss", 32'({level[2], rise[2]}), 32'h0);
      end
      // Exactly four samples are enough
      raw = 4'b0100;
      ticks(4);
      raw = 4'b0000;
      ticks(1);
      chk("exact_early", 32'(rise), 32'h0);
      ticks(1);
      chk("exact_rise", 32'(rise), 32'h4);
      chk("exact_lvl", 32'(level), 32'h4);
      ticks(8);
      chk("exact_release", 32'(level), 32'h0);

      // Long hold on bit 3: one pulse, 8 cycles after rise
      raw = 4'b1000;
      ticks(6);
      chk("hold_rise", 32'(rise), 32'h8);
      for (int j = 1; j <= 12; j++) begin
         ticks(1);
         chk("hold_pulse", 32'(held), (j == 8) ? 32'h8 : 32'h0);
      end
      raw = 4'b0000;
      ticks(5);
      chk("hold_rel_early", {level, fall, held}, 12'h800);
      ticks(1);
      chk("hold_fall", 32'(fall), 32'h8);
      chk("hold_lvl_low", 32'(level), 32'h0);
      // Second press re-arms the hold detector
      ticks(2);
      raw = 4'b1000;
      ticks(6);
      chk("rearm_rise", 32'(rise), 32'h8);
      ticks(7);
      chk("rearm_early", 32'(held), 32'h0);
      ticks(1);
      chk("rearm_held", 32'(held), 32'h8);
      raw = 4'b0000;
      ticks(8);

      // Simultaneous press on bits 0 and 2
      raw = 4'b0101;
      ticks(5);
      chk("simul_early", 32'(rise), 32'h0);
      ticks(1);
      chk("simul_rise", 32'(rise), 32'h5);
      ticks(1);
      chk("simul_rise_clr", 32'(rise), 32'h0);
      raw = 4'b0000;
      ticks(6);
      chk("simul_fall", 32'(fall), 32'h5);
      ticks(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
